// File: rtl/slc3_control_if.sv
// rtl/slc3_control_if.sv - control/datapath signal bundle for the SLC-3 control FSM
interface slc3_control_if;
  logic        run;
  logic        cont;
  logic [15:0] ir;
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, ld_ir, ld_reg, ld_pc;
  logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic        sr2mux, addr1mux;
  logic [1:0]  addr2mux, pcmux, aluk;
  logic        drmux, sr1mux, mio_en, mem_oe, mem_we;
  logic [2:0]  nzp;
  logic        ben;
  logic        halted;

  modport master (
    input  run, cont, ir, bus,
    output ld_mar, ld_mdr, ld_ir, ld_reg, ld_pc,
    output gate_pc, gate_mdr, gate_alu, gate_marmux,
    output sr2mux, addr1mux, addr2mux, pcmux, aluk,
    output drmux, sr1mux, mio_en, mem_oe, mem_we,
    output nzp, ben, halted
  );

  modport slave (
    output run, cont, ir, bus,
    input  ld_mar, ld_mdr, ld_ir, ld_reg, ld_pc,
    input  gate_pc, gate_mdr, gate_alu, gate_marmux,
    input  sr2mux, addr1mux, addr2mux, pcmux, aluk,
    input  drmux, sr1mux, mio_en, mem_oe, mem_we,
    input  nzp, ben, halted
  );
endinterface

// File: rtl/slc3_control.sv
// rtl/slc3_control.sv - SLC-3 fetch/decode/execute control FSM with NZP and BEN
module slc3_control #(
  parameter int MEM_WAIT = 2
) (
  input logic          clk,
  input logic          rst,
  slc3_control_if.master ctl
);
  typedef enum logic [4:0] {
    S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_ALU, S_BR1, S_JMP1, S_JSR1, S_JSR2,
    S_LDR1, S_LDR2, S_LDR3, S_STR1, S_STR2, S_STR3,
    S_PAUSE1, S_PAUSE2
  } state_t;

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(MEM_WAIT - 1);

  state_t        state, next;
  logic [CW-1:0] cnt;
  logic [2:0]    nzp_q;
  logic          ben_q;
  logic          last;
  logic          mem_entry;

  assign last       = (cnt == '0);
  assign mem_entry  = (next != state) &&
                      (next == S_FETCH2 || next == S_LDR2 || next == S_STR3);
  assign ctl.nzp    = nzp_q;
  assign ctl.ben    = ben_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HALTED;
      cnt   <= '0;
      nzp_q <= 3'b010;
      ben_q <= 1'b0;
    end else begin
      state <= next;
      if (mem_entry)
        cnt <= WAIT_INIT;
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
      if (ctl.ld_reg)
        nzp_q <= {ctl.bus[15], ctl.bus == 16'h0000, ~ctl.bus[15] & (ctl.bus != 16'h0000)};
      if (state == S_DECODE)
        ben_q <= |(ctl.ir[11:9] & nzp_q);
    end
  end

  always_comb begin
    state_t retire;
    retire          = ctl.run ? S_FETCH1 : S_HALTED;
    next            = state;
    ctl.ld_mar      = 1'b0;
    ctl.ld_mdr      = 1'b0;
    ctl.ld_ir       = 1'b0;
    ctl.ld_reg      = 1'b0;
    ctl.ld_pc       = 1'b0;
    ctl.gate_pc     = 1'b0;
    ctl.gate_mdr    = 1'b0;
    ctl.gate_alu    = 1'b0;
    ctl.gate_marmux = 1'b0;
    ctl.sr2mux      = 1'b0;
    ctl.addr1mux    = 1'b0;
    ctl.addr2mux    = 2'b00;
    ctl.pcmux       = 2'b00;
    ctl.aluk        = 2'b00;
    ctl.drmux       = 1'b0;
    ctl.sr1mux      = 1'b0;
    ctl.mio_en      = 1'b0;
    ctl.mem_oe      = 1'b0;
    ctl.mem_we      = 1'b0;
    ctl.halted      = 1'b0;

    case (state)
      S_HALTED: begin
        ctl.halted = 1'b1;
        if (ctl.run) next = S_FETCH1;
      end
      S_FETCH1: begin
        ctl.gate_pc = 1'b1;
        ctl.ld_mar  = 1'b1;
        ctl.ld_pc   = 1'b1;
        next        = S_FETCH2;
      end
      S_FETCH2: begin
        ctl.mem_oe = 1'b1;
        if (last) begin
          ctl.mio_en = 1'b1;
          ctl.ld_mdr = 1'b1;
          next       = S_FETCH3;
        end
      end
      S_FETCH3: begin
        ctl.gate_mdr = 1'b1;
        ctl.ld_ir    = 1'b1;
        next         = S_DECODE;
      end
      S_DECODE: begin
        case (ctl.ir[15:12])
          4'b0001, 4'b0101, 4'b1001: next = S_ALU;
          4'b0000: next = S_BR1;
          4'b1100: next = S_JMP1;
          4'b0100: next = S_JSR1;
          4'b0110: next = S_LDR1;
          4'b0111: next = S_STR1;
          4'b1101: next = S_PAUSE1;
          default: next = retire;
        endcase
      end
      S_ALU: begin
        ctl.gate_alu = 1'b1;
        ctl.ld_reg   = 1'b1;
        ctl.sr1mux   = 1'b1;
        ctl.sr2mux   = ctl.ir[5];
        ctl.aluk     = (ctl.ir[15:12] == 4'b1001) ? 2'b10 :
                       (ctl.ir[15:12] == 4'b0101) ? 2'b01 : 2'b00;
        next         = retire;
      end
      S_BR1: begin
        if (ben_q) begin
          ctl.addr2mux = 2'b10;
          ctl.pcmux    = 2'b10;
          ctl.ld_pc    = 1'b1;
        end
        next = retire;
      end
      S_JMP1: begin
        ctl.sr1mux   = 1'b1;
        ctl.aluk     = 2'b11;
        ctl.gate_alu = 1'b1;
        ctl.pcmux    = 2'b01;
        ctl.ld_pc    = 1'b1;
        next         = retire;
      end
      S_JSR1: begin
        ctl.gate_pc = 1'b1;
        ctl.drmux   = 1'b1;
        ctl.ld_reg  = 1'b1;
        next        = S_JSR2;
      end
      S_JSR2: begin
        ctl.addr2mux = 2'b11;
        ctl.pcmux    = 2'b10;
        ctl.ld_pc    = 1'b1;
        next         = retire;
      end
      // Base register for LDR/STR addressing is IR[8:6].
      S_LDR1, S_STR1: begin
        ctl.sr1mux      = 1'b1;
        ctl.addr1mux    = 1'b1;
        ctl.addr2mux    = 2'b01;
        ctl.gate_marmux = 1'b1;
        ctl.ld_mar      = 1'b1;
        next            = (state == S_LDR1) ? S_LDR2 : S_STR2;
      end
      S_LDR2: begin
        ctl.mem_oe = 1'b1;
        if (last) begin
          ctl.mio_en = 1'b1;
          ctl.ld_mdr = 1'b1;
          next       = S_LDR3;
        end
      end
      S_LDR3: begin
        ctl.gate_mdr = 1'b1;
        ctl.ld_reg   = 1'b1;
        next         = retire;
      end
      S_STR2: begin
        ctl.aluk     = 2'b11;
        ctl.gate_alu = 1'b1;
        ctl.ld_mdr   = 1'b1;
        next         = S_STR3;
      end
      S_STR3: begin
        ctl.mem_we = 1'b1;
        if (last) next = retire;
      end
      S_PAUSE1: if (ctl.cont) next = S_PAUSE2;
      S_PAUSE2: if (!ctl.cont) next = retire;
      default: next = S_HALTED;
    endcase
  end
endmodule

// File: tb/tb_slc3_control.sv
// tb/tb_slc3_control.sv - scoreboard bench for slc3_control with a per-instruction micro-op model
module tb_slc3_control;
  localparam int W     = 3;
  localparam int N     = 40;
  localparam int LIMIT = 8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slc3_control_if bif();
  slc3_control #(.MEM_WAIT(W)) dut (.clk(clk), .rst(rst), .ctl(bif));

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_reg, ld_pc;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic sr2mux, addr1mux;
    logic [1:0] addr2mux, pcmux, aluk;
    logic drmux, sr1mux, mio_en, mem_oe, mem_we;
  } ctl_t;

  typedef struct packed {
    ctl_t       c;
    logic [2:0] nzp;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] prog_ir[$];
  logic [15:0] prog_bus[$];
  logic [2:0]  nzp_m;
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;

  function automatic ctl_t observe();
    ctl_t c;
    c.ld_mar = bif.ld_mar; c.ld_mdr = bif.ld_mdr; c.ld_ir = bif.ld_ir;
    c.ld_reg = bif.ld_reg; c.ld_pc = bif.ld_pc;
    c.gate_pc = bif.gate_pc; c.gate_mdr = bif.gate_mdr;
    c.gate_alu = bif.gate_alu; c.gate_marmux = bif.gate_marmux;
    c.sr2mux = bif.sr2mux; c.addr1mux = bif.addr1mux;
    c.addr2mux = bif.addr2mux; c.pcmux = bif.pcmux; c.aluk = bif.aluk;
    c.drmux = bif.drmux; c.sr1mux = bif.sr1mux; c.mio_en = bif.mio_en;
    c.mem_oe = bif.mem_oe; c.mem_we = bif.mem_we;
    return c;
  endfunction

  function automatic logic [2:0] nzp_of(logic [15:0] b);
    if (b == 16'h0000) return 3'b010;
    if (b[15]) return 3'b100;
    return 3'b001;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push(ctl_t c);
    exp_t e;
    e.c   = c;
    e.nzp = nzp_m;
    sb.push_back(e);
  endtask

  task automatic push_mem(bit rd);
    ctl_t c;
    for (int k = 0; k < W; k++) begin
      c = '0;
      if (rd) c.mem_oe = 1'b1; else c.mem_we = 1'b1;
      if (rd && k == W - 1) begin c.mio_en = 1'b1; c.ld_mdr = 1'b1; end
      push(c);
    end
  endtask

  // Every cycle that loads a register or strobes memory is one expected record.
  task automatic build_expected();
    ctl_t        c;
    logic [15:0] ir;
    logic [3:0]  op;
    nzp_m = 3'b010;
    for (int i = 0; i < prog_ir.size(); i++) begin
      ir = prog_ir[i];
      op = ir[15:12];
      c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; push(c);
      push_mem(1'b1);
      c = '0; c.gate_mdr = 1; c.ld_ir = 1; push(c);
      case (op)
        4'b0001, 4'b0101, 4'b1001: begin
          c = '0; c.gate_alu = 1; c.ld_reg = 1; c.sr1mux = 1; c.sr2mux = ir[5];
          c.aluk = (op == 4'b1001) ? 2'd2 : (op == 4'b0101) ? 2'd1 : 2'd0;
          push(c); nzp_m = nzp_of(prog_bus[i]);
        end
        4'b0000: if ((ir[11:9] & nzp_m) != 3'b000) begin
          c = '0; c.ld_pc = 1; c.pcmux = 2'd2; c.addr2mux = 2'd2; push(c);
        end
        4'b1100: begin
          c = '0; c.sr1mux = 1; c.aluk = 2'd3; c.gate_alu = 1; c.pcmux = 2'd1; c.ld_pc = 1; push(c);
        end
        4'b0100: begin
          c = '0; c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; push(c);
          nzp_m = nzp_of(prog_bus[i]);
          c = '0; c.addr2mux = 2'd3; c.pcmux = 2'd2; c.ld_pc = 1; push(c);
        end
        4'b0110, 4'b0111: begin
          c = '0; c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'd1; c.gate_marmux = 1; c.ld_mar = 1;
          push(c);
          if (op == 4'b0110) begin
            push_mem(1'b1);
            c = '0; c.gate_mdr = 1; c.ld_reg = 1; push(c);
            nzp_m = nzp_of(prog_bus[i]);
          end else begin
            c = '0; c.aluk = 2'd3; c.gate_alu = 1; c.ld_mdr = 1; push(c);
            push_mem(1'b0);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic monitor();
    ctl_t got;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        total++;
        if ($countones({bif.gate_pc, bif.gate_mdr, bif.gate_alu, bif.gate_marmux}) > 1) begin
          bad++;
          $display("FAIL gate_onehot got=%b want=at most one", {bif.gate_pc, bif.gate_mdr, bif.gate_alu, bif.gate_marmux});
        end
        got = observe();
        if (got.ld_mar | got.ld_mdr | got.ld_ir | got.ld_reg | got.ld_pc | got.mem_oe | got.mem_we) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe got=%h want=none", got);
          end else begin
            e = sb.pop_front();
            if (got !== e.c || bif.nzp !== e.nzp) begin
              bad++;
              $display("FAIL ctl_word got=%h nzp=%b want=%h nzp=%b", got, bif.nzp, e.c, e.nzp);
            end
          end
        end
      end
    end
  endtask

  task automatic pause_seq();
    int r;
    r = $urandom_range(2, 5);
    repeat (r) begin
      @(negedge clk);
      check("pause_hold_low", {31'd0, bif.ld_mar}, 32'd0);
    end
    bif.cont = 1'b1;
    r = $urandom_range(2, 4);
    repeat (r) begin
      @(negedge clk);
      check("pause_hold_high", {31'd0, bif.ld_mar}, 32'd0);
    end
    bif.cont = 1'b0;
  endtask

  logic [15:0] rv;
  int          pc_idx;
  int          cycles;
  int          hits;

  initial begin
    rst = 1'b1;
    bif.run = 1'b0; bif.cont = 1'b0; bif.ir = 16'h0000; bif.bus = 16'h0000;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    check("reset_halted", {31'd0, bif.halted}, 32'd1);
    check("reset_nzp", {29'd0, bif.nzp}, 32'd2);
    check("reset_ben", {31'd0, bif.ben}, 32'd0);
    check("reset_ctl", {8'd0, observe()}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_halted", {31'd0, bif.halted}, 32'd1);

    // Directed prefix, then random instructions, then a final ADD.
    prog_ir  = '{16'h0802, 16'h1261, 16'h1261, 16'h0802, 16'h7240, 16'hD0FF, 16'h6281};
    prog_bus = '{16'h0000, 16'h0005, 16'h8001, 16'h0000, 16'h1234, 16'h0000, 16'h0000};
    while (prog_ir.size() < N - 1) begin
      rv = 16'($urandom);
      prog_ir.push_back(rv);
      case ($urandom_range(0, 2))
        0: prog_bus.push_back(16'h0000);
        1: prog_bus.push_back({1'b0, 15'($urandom_range(1, 32767))});
        default: prog_bus.push_back({1'b1, 15'($urandom)});
      endcase
    end
    prog_ir.push_back(16'h1261);
    prog_bus.push_back(16'h0007);
    build_expected();

    mon_en  = 1'b1;
    bif.run = 1'b1;
    pc_idx  = 0;
    cycles  = 0;
    while (pc_idx < N) begin
      @(negedge clk);
      cycles++;
      if (cycles > LIMIT) begin
        check("program_timeout", cycles, 0);
        break;
      end
      if (bif.ld_ir) begin
        bif.ir  = prog_ir[pc_idx];
        bif.bus = prog_bus[pc_idx];
        pc_idx++;
        if (pc_idx == N) bif.run = 1'b0;
        if (bif.ir[15:12] == 4'hD) pause_seq();
      end
    end
    cycles = 0;
    while (!bif.halted && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("final_halted", {31'd0, bif.halted}, 32'd1);
    check("sb_drained", sb.size(), 0);
    check("final_nzp", {29'd0, bif.nzp}, {29'd0, nzp_m});
    mon_en = 1'b0;

    // Asynchronous reset in the middle of an LDR memory read.
    bif.ir  = 16'h6281;
    bif.bus = 16'h8000;
    bif.run = 1'b1;
    hits    = 0;
    cycles  = 0;
    while (hits < 2 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (bif.gate_marmux && bif.ld_mar) hits++;
    end
    check("ldr1_seen", hits, 2);
    @(negedge clk);
    check("ldr2_mem_oe", {31'd0, bif.mem_oe}, 32'd1);
    check("ldr2_nzp", {29'd0, bif.nzp}, 32'd4);
    #2 rst = 1'b1;
    #1;
    check("arst_halted", {31'd0, bif.halted}, 32'd1);
    check("arst_mem_oe", {31'd0, bif.mem_oe}, 32'd0);
    check("arst_nzp", {29'd0, bif.nzp}, 32'd2);
    check("arst_ctl", {8'd0, observe()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bif.run = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
